mem_bus_arbiter: RTL and testbench

- Round-robin arbiter and access sequencer for the shared 16-bit memory/I-O address bus.
- Requesters are the sine-table reader, the LFSR noise logger and the 7-segment display fetcher (NREQ=3).
- Downstream it drives the program address map (SRAM_0, SRAM_1, Output_Port, Input_Port) and the Flash data region.
- Per transaction: decodes the region, inserts region-specific wait states, drives the SRAM chip enable, and returns read data with a one-cycle done pulse.

---
 rtl/mem_bus_arbiter_pkg.sv | 21 ++
 rtl/mem_bus_arbiter_pick.sv | 19 +
 rtl/mem_bus_arbiter.sv | 117 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared states, region codes and wait counts for the memory bus arbiter
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ACCESS, S_DONE} state_t;
  localparam logic [2:0] REG_SRAM0 = 3'd0;
  localparam logic [2:0] REG_SRAM1 = 3'd1;
  localparam logic [2:0] REG_OUT = 3'd2;
  localparam logic [2:0] REG_IN = 3'd3;
  localparam logic [2:0] REG_FLASH = 3'd4;
  localparam logic [15:0] REGION_SRAM1 = 16'h2000;
  localparam logic [15:0] REGION_OUT = 16'h4000;
  localparam logic [15:0] REGION_IN = 16'h6000;
  localparam logic [15:0] REGION_FLASH = 16'h8000;
  localparam int DEF_SRAM_WAIT = 1;
  localparam int DEF_FLASH_WAIT = 3;
  function automatic logic [2:0] decode_region(input logic [15:0] a);
    return a >= REGION_FLASH ? REG_FLASH :
           a >= REGION_IN    ? REG_IN :
           a >= REGION_OUT   ? REG_OUT :
           a >= REGION_SRAM1 ? REG_SRAM1 : REG_SRAM0;
  endfunction
endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// rr_priority_pick: first asserted request at or after ptr, searching upward with wrap-around
module rr_priority_pick #(
  parameter int NREQ = 3,
  parameter int PW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   idx,
  output logic            any
);
  always_comb begin
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--)
      if (req[PW'((int'(ptr) + i) % NREQ)]) idx = PW'((int'(ptr) + i) % NREQ);
    any = |req;
    pick = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter and wait-state sequencer for the shared memory/I-O bus
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int N = 4,
  parameter int NREQ = 3,
  parameter int SRAM_WAIT = DEF_SRAM_WAIT,
  parameter int FLASH_WAIT = DEF_FLASH_WAIT
) (
  input  logic              clk,
  input  logic              nRESET,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N*4-1:0] req_addr,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*N*2-1:0] req_wdata,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [N*2-1:0]    rdata,
  output logic [N*4-1:0]    bus_addr,
  output logic [N*2-1:0]    bus_wdata,
  output logic              bus_we,
  input  logic [N*2-1:0]    bus_rdata,
  output logic              CE,
  output logic [2:0]        region,
  output logic              busy
);
  localparam int AW = N * 4;
  localparam int DW = N * 2;
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
  state_t state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, gidx_q, gidx_d, pick_idx;
  logic [NREQ-1:0] gnt_q, gnt_d, pick;
  logic pick_any, active;
  logic [3:0] cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic we_q, we_d;
  logic [2:0] region_q, region_d;
  rr_priority_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req(req), .ptr(rr_ptr_q), .pick(pick), .idx(pick_idx), .any(pick_any)
  );
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    gidx_d = gidx_q;
    gnt_d = gnt_q;
    cnt_d = cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    we_d = we_q;
    region_d = region_q;
    case (state_q)
      S_IDLE: if (pick_any) begin
        state_d = S_GRANT;
        gidx_d = pick_idx;
        gnt_d = pick;
        addr_d = req_addr[pick_idx*AW +: AW];
        wdata_d = req_wdata[pick_idx*DW +: DW];
        we_d = req_we[pick_idx];
        region_d = decode_region(addr_d[AW-1 -: 16]);
      end
      S_GRANT: begin
        state_d = S_ACCESS;
        cnt_d = region_q == REG_FLASH ? 4'(FLASH_WAIT) : 4'(SRAM_WAIT);
      end
      S_ACCESS: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = S_DONE;
          cnt_d = '0;
          rdata_d = bus_rdata;
        end
      end
      default: begin
        state_d = S_IDLE;
        rr_ptr_d = gidx_q == PW'(NREQ - 1) ? '0 : gidx_q + PW'(1);
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state_q <= S_IDLE;
      rr_ptr_q <= '0;
      gidx_q <= '0;
      gnt_q <= '0;
      cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      we_q <= 1'b0;
      region_q <= '0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gidx_q <= gidx_d;
      gnt_q <= gnt_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      we_q <= we_d;
      region_q <= region_d;
    end
  end
  // Input_Port and Flash are not writable, so their write strobe never reaches the bus
  assign active = state_q == S_GRANT || state_q == S_ACCESS;
  assign busy = state_q != S_IDLE;
  assign gnt = busy ? gnt_q : '0;
  assign done = state_q == S_DONE ? gnt_q : '0;
  assign CE = active && region_q <= REG_SRAM1;
  assign bus_we = active && we_q && region_q < REG_IN;
  assign bus_addr = addr_q;
  assign bus_wdata = wdata_q;
  assign region = region_q;
  assign rdata = rdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed and randomized transactions checked against a round-robin bus model
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic nRESET = 1'b0;
  logic [2:0] req = '0, req_we = '0;
  logic [47:0] req_addr = '0;
  logic [23:0] req_wdata = '0;
  logic [7:0] bus_rdata = '0;
  logic [2:0] gnt, done, region;
  logic [7:0] rdata, bus_wdata;
  logic [15:0] bus_addr;
  logic bus_we, CE, busy;
  int vectors = 0, errors = 0, ptr = 0, w;
  always #5 clk = ~clk;
  mem_bus_arbiter dut (
    .clk(clk), .nRESET(nRESET), .req(req), .req_addr(req_addr), .req_we(req_we),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(bus_rdata), .CE(CE),
    .region(region), .busy(busy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  function automatic int exp_region(input logic [15:0] a);
    logic [2:0] top;
    top = a[15:13];
    case (top)
      3'b000: return 0;
      3'b001: return 1;
      3'b010: return 2;
      3'b011: return 3;
      default: return 4;
    endcase
  endfunction
  function automatic int winner();
    for (int o = 0; o < 3; o++)
      if (req[2'((ptr + o) % 3)]) return (ptr + o) % 3;
    return -1;
  endfunction
  task automatic post(input int i, input logic [15:0] a, input logic we, input logic [7:0] d);
    req[2'(i)] = 1'b1;
    req_we[2'(i)] = we;
    req_addr[i*16 +: 16] = a;
    req_wdata[i*8 +: 8] = d;
  endtask
  task automatic chk_zero();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_addr", 32'(bus_addr), 0);
    chk("rst_wdata", 32'(bus_wdata), 0);
    chk("rst_we", 32'(bus_we), 0);
    chk("rst_ce", 32'(CE), 0);
    chk("rst_region", 32'(region), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rdata", 32'(rdata), 0);
  endtask
  // Called at a falling edge while the DUT is idle; runs one whole transaction cycle by cycle.
  task automatic serve(input bit withdraw, input bit add, input logic [7:0] rd, output int wo);
    int r, nw;
    logic [15:0] a;
    logic [7:0] d;
    logic ce, we_e;
    wo = winner();
    if (wo < 0) return;
    a = req_addr[wo*16 +: 16];
    d = req_wdata[wo*8 +: 8];
    r = exp_region(a);
    nw = r == 4 ? 3 : 1;
    ce = r < 2;
    we_e = req_we[2'(wo)] && r < 3;
    @(negedge clk);
    chk("gnt_grant", 32'(gnt), 32'(1) << wo);
    chk("busy_grant", 32'(busy), 1);
    chk("region", 32'(region), 32'(r));
    chk("bus_addr", 32'(bus_addr), 32'(a));
    chk("bus_wdata", 32'(bus_wdata), 32'(d));
    chk("ce_grant", 32'(CE), 32'(ce));
    chk("we_grant", 32'(bus_we), 32'(we_e));
    bus_rdata = rd;
    if (add)
      for (int i = 0; i < 3; i++)
        if (i != wo && !req[2'(i)] && $urandom_range(1) == 1)
          post(i, 16'($urandom), 1'($urandom), 8'($urandom));
    for (int c = 0; c < nw; c++) begin
      @(negedge clk);
      chk("done_early", 32'(done), 0);
      chk("ce_access", 32'(CE), 32'(ce));
      chk("we_access", 32'(bus_we), 32'(we_e));
      chk("addr_hold", 32'(bus_addr), 32'(a));
      if (withdraw && c == 0) req[2'(wo)] = 1'b0;
    end
    @(negedge clk);
    chk("done", 32'(done), 32'(1) << wo);
    chk("gnt_done", 32'(gnt), 32'(1) << wo);
    chk("rdata", 32'(rdata), 32'(rd));
    chk("ce_done", 32'(CE), 0);
    chk("we_done", 32'(bus_we), 0);
    req[2'(wo)] = 1'b0;
    ptr = (wo + 1) % 3;
    bus_rdata = 8'($urandom);
    @(negedge clk);
    chk("gnt_idle", 32'(gnt), 0);
    chk("busy_idle", 32'(busy), 0);
    chk("done_idle", 32'(done), 0);
    chk("rdata_hold", 32'(rdata), 32'(rd));
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_zero();
    nRESET = 1'b1;
    post(0, 16'h1AB9, 1'b0, 8'h00);
    serve(1'b0, 1'b0, 8'h5A, w);
    post(1, 16'hA004, 1'b0, 8'h00);
    serve(1'b0, 1'b0, 8'hC3, w);
    post(2, 16'h700F, 1'b1, 8'hFF);
    serve(1'b0, 1'b0, 8'h3C, w);
    post(0, 16'h33A7, 1'b0, 8'h11);
    post(1, 16'h58FB, 1'b1, 8'h22);
    post(2, 16'h700F, 1'b0, 8'h33);
    for (int k = 0; k < 3; k++) begin
      serve(1'b0, 1'b0, 8'($urandom), w);
      req[2'(w)] = 1'b1;
    end
    for (int k = 0; k < 3; k++) serve(1'b0, 1'b0, 8'($urandom), w);
    post(0, 16'h0123, 1'b1, 8'h5E);
    serve(1'b1, 1'b0, 8'h81, w);
    post(0, 16'h0456, 1'b0, 8'h00);
    post(1, 16'h2222, 1'b0, 8'h00);
    serve(1'b0, 1'b0, 8'h92, w);
    serve(1'b0, 1'b0, 8'hA3, w);
    post(1, 16'hA004, 1'b0, 8'h00);
    bus_rdata = 8'h77;
    repeat (3) @(negedge clk);
    nRESET = 1'b0;
    @(negedge clk);
    chk_zero();
    req = '0;
    nRESET = 1'b1;
    ptr = 0;
    post(2, 16'h6001, 1'b0, 8'h00);
    post(0, 16'hFFFF, 1'b0, 8'h00);
    serve(1'b0, 1'b0, 8'hB4, w);
    serve(1'b0, 1'b0, 8'hC5, w);
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < 3; i++)
        if (!req[2'(i)] && $urandom_range(2) != 0)
          post(i, 16'($urandom), 1'($urandom), 8'($urandom));
      for (int s = 0; s < 8 && req != 0; s++)
        serve($urandom_range(3) == 0, $urandom_range(1) == 1, 8'($urandom), w);
      while (req != 0) serve(1'b0, 1'b0, 8'($urandom), w);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
